// File: rtl/light_package.sv
// rtl/light_package.sv - phase and scheduler FSM state types shared by traffic_phase_scheduler
package light_package;

    typedef enum logic [1:0] {
        PH_EW_STR  = 2'd0,
        PH_EW_LEFT = 2'd1,
        PH_NS      = 2'd2,
        PH_PED     = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_HOLD  = 2'd2
    } tps_state_t;

    localparam int NUM_PHASES = 4;

endpackage

// File: rtl/tps_rr_select.sv
// rtl/tps_rr_select.sv - combinational phase pick: lowest starved index, else round-robin after rr_ptr
import light_package::*;

module tps_rr_select (
    input  logic [3:0] req,
    input  logic [3:0] starved,
    input  logic [1:0] rr_ptr,
    output logic [1:0] sel,
    output logic       any
);

    always_comb begin
        sel = PH_EW_STR;
        any = |req;
        if (|starved) begin
            for (int i = NUM_PHASES - 1; i >= 0; i--) begin
                if (starved[i]) sel = 2'(i);
            end
        end else begin
            // Walk backwards so the candidate nearest rr_ptr+1 is written last and wins.
            for (int k = NUM_PHASES; k >= 1; k--) begin
                if (req[2'(int'(rr_ptr) + k)]) sel = 2'(int'(rr_ptr) + k);
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - request latch, aging and grant FSM; TPS_EMERG_PREEMPT_EN adds emergency preemption
import light_package::*;

module traffic_phase_scheduler #(
    parameter int AGE_MAX = 20,
    parameter int AGE_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ew_str_sensor,
    input  logic       ew_left_sensor,
    input  logic       ns_sensor,
    input  logic       ped_button,
    output logic       grant_valid,
    output logic [1:0] grant_phase,
    input  logic       grant_ready,
    input  logic       phase_done,
    output logic [3:0] pending,
    output logic       starve
`ifdef TPS_EMERG_PREEMPT_EN
    ,
    input  logic       emerg_req,
    input  logic [1:0] emerg_phase,
    output logic       preempt
`endif
);

    tps_state_t       state;
    logic [3:0]       req;
    logic [AGE_W-1:0] age [NUM_PHASES];
    logic [3:0]       starved;
    logic [3:0]       sens;
    logic [1:0]       rr_ptr;
    logic [1:0]       rr_sel;
    logic             rr_any;
    logic [1:0]       sel;
    logic             sel_any;
    logic             hs;

    assign sens    = {ped_button, ns_sensor, ew_left_sensor, ew_str_sensor};
    assign hs      = grant_valid && grant_ready;
    assign pending = req;
    assign starve  = |starved;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            starved[i] = (age[i] == AGE_W'(AGE_MAX));
        end
    end

    tps_rr_select u_select (
        .req     (req),
        .starved (starved),
        .rr_ptr  (rr_ptr),
        .sel     (rr_sel),
        .any     (rr_any)
    );

`ifdef TPS_EMERG_PREEMPT_EN
    logic emerg_grant;
    assign sel     = emerg_req ? emerg_phase : rr_sel;
    assign sel_any = rr_any || emerg_req;
`else
    assign sel     = rr_sel;
    assign sel_any = rr_any;
`endif

    // The served phase's clear takes priority over a sensor still high on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req <= '0;
            for (int i = 0; i < NUM_PHASES; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (hs && grant_phase == 2'(i)) begin
                    req[i] <= 1'b0;
                    age[i] <= '0;
                end else begin
                    req[i] <= req[i] | sens[i];
                    if (!req[i])
                        age[i] <= '0;
                    else if (!starved[i])
                        age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            grant_valid <= 1'b0;
            grant_phase <= PH_EW_STR;
            rr_ptr      <= PH_PED;
`ifdef TPS_EMERG_PREEMPT_EN
            emerg_grant <= 1'b0;
            preempt     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_any) begin
                        state       <= S_OFFER;
                        grant_valid <= 1'b1;
                        grant_phase <= sel;
`ifdef TPS_EMERG_PREEMPT_EN
                        emerg_grant <= emerg_req;
`endif
                    end
                end
                S_OFFER: begin
                    if (grant_ready) begin
                        state       <= S_HOLD;
                        grant_valid <= 1'b0;
`ifdef TPS_EMERG_PREEMPT_EN
                        if (!emerg_grant) rr_ptr <= grant_phase;
                    end else if (emerg_req) begin
                        grant_phase <= emerg_phase;
                        emerg_grant <= 1'b1;
`else
                        rr_ptr      <= grant_phase;
`endif
                    end
                end
                S_HOLD: begin
                    if (phase_done) begin
                        if (sel_any) begin
                            state       <= S_OFFER;
                            grant_valid <= 1'b1;
                            grant_phase <= sel;
`ifdef TPS_EMERG_PREEMPT_EN
                            emerg_grant <= emerg_req;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
`ifdef TPS_EMERG_PREEMPT_EN
            preempt <= (state == S_HOLD) && emerg_req && (emerg_phase != grant_phase);
`endif
        end
    end

endmodule
